// File: rtl/fabric_port_pkg.sv
// Shared definitions for the fabric output-port arbiter: lane geometry, arbiter states
// and the per-beat packet-open scan.
package fabric_port_pkg;

    localparam int NUM_LANES          = 4;
    localparam int LANE_HEAD          = NUM_LANES - 1;  // lane 3 is first in packet order
    localparam int WIDTH_DATA_DEFAULT = 546;            // 512 data + 32 + 1 + 1

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic is_open;
        logic err;
    } scan_result_t;

    // Walk the valid lanes head-first, tracking whether a packet is open after each lane.
    function automatic scan_result_t scan_lanes(
        input logic                 open_in,
        input logic [NUM_LANES-1:0] valid,
        input logic [NUM_LANES-1:0] sop,
        input logic [NUM_LANES-1:0] eop
    );
        scan_result_t r;
        r.is_open = open_in;
        r.err     = 1'b0;
        for (int l = LANE_HEAD; l >= 0; l--) begin
            if (valid[l]) begin
                if (sop[l]) begin
                    if (r.is_open) r.err = 1'b1;
                    r.is_open = !eop[l];
                end else begin
                    if (!r.is_open) r.err = 1'b1;
                    if (eop[l]) r.is_open = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fabric_port_rr_arb.sv
// Combinational N-way round-robin selector: first requester at or after ptr_i wins.
module fabric_port_rr_arb #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o
);

    logic found;
    int   cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = PTR_W'(cand);
            end
        end
        if (found) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/fabric_port_out_arbiter.sv
// Packet-atomic round-robin arbiter sharing one registered 4-lane fabric output port
// between N_PORTS depacketizer streams.
module fabric_port_out_arbiter
    import fabric_port_pkg::*;
#(
    parameter int  N_PORTS    = 2,
    parameter int  WIDTH_DATA = WIDTH_DATA_DEFAULT,
    localparam int PTR_W      = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS*WIDTH_DATA-1:0] i_data_in,
    input  logic [4*N_PORTS-1:0]          i_valid_in,
    input  logic [4*N_PORTS-1:0]          i_sop_in,
    input  logic [4*N_PORTS-1:0]          i_eop_in,
    output logic [N_PORTS-1:0]            i_ready_out,
    output logic [WIDTH_DATA-1:0]         o_data_out,
    output logic [3:0]                    o_valid_out,
    output logic [3:0]                    o_sop_out,
    output logic [3:0]                    o_eop_out,
    input  logic                          o_ready_in,
    output logic [PTR_W-1:0]              o_grant_port,
    output logic                          o_proto_err
);

    arb_state_e                 state_q, state_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]           lock_port_q, lock_port_d;

    logic [WIDTH_DATA-1:0]      data_q;
    logic [NUM_LANES-1:0]       valid_q, sop_q, eop_q;
    logic [PTR_W-1:0]           grant_q;
    logic                       err_q;

    logic [N_PORTS-1:0]         present;
    logic [N_PORTS-1:0]         arb_grant;
    logic [PTR_W-1:0]           arb_idx;
    logic [N_PORTS-1:0]         grant_onehot;
    logic [PTR_W-1:0]           sel;
    logic                       accept;
    logic                       transfer;
    logic [WIDTH_DATA-1:0]      sel_data;
    logic [NUM_LANES-1:0]       sel_valid, sel_sop, sel_eop;
    scan_result_t               scan;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_present
            assign present[gi] = |i_valid_in[gi*NUM_LANES +: NUM_LANES];
        end
    endgenerate

    fabric_port_rr_arb #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req_i   (present),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    // Only the locked port can have a packet open, so the FSM state is the open flag.
    always_comb begin
        grant_onehot = '0;
        sel          = lock_port_q;
        if (state_q == ST_IDLE) begin
            grant_onehot = arb_grant;
            sel          = arb_idx;
        end else begin
            grant_onehot[lock_port_q] = 1'b1;
        end
        accept      = !(|valid_q) || o_ready_in;
        i_ready_out = accept ? grant_onehot : '0;
        transfer    = accept && (|(present & grant_onehot));
        sel_data    = i_data_in[int'(sel)*WIDTH_DATA +: WIDTH_DATA];
        sel_valid   = i_valid_in[int'(sel)*NUM_LANES +: NUM_LANES];
        sel_sop     = i_sop_in[int'(sel)*NUM_LANES +: NUM_LANES];
        sel_eop     = i_eop_in[int'(sel)*NUM_LANES +: NUM_LANES];
        scan        = scan_lanes(state_q == ST_LOCKED, sel_valid, sel_sop, sel_eop);

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_port_d = lock_port_q;
        if (transfer) begin
            if (scan.is_open) begin
                state_d     = ST_LOCKED;
                lock_port_d = sel;
            end else begin
                state_d  = ST_IDLE;
                rr_ptr_d = (sel == PTR_W'(N_PORTS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            lock_port_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_port_q <= lock_port_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            sop_q   <= '0;
            eop_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                if (transfer) begin
                    data_q  <= sel_data;
                    valid_q <= sel_valid;
                    sop_q   <= sel_sop;
                    eop_q   <= sel_eop;
                    grant_q <= sel;
                end else begin
                    valid_q <= '0;
                    sop_q   <= '0;
                    eop_q   <= '0;
                end
            end
            if (transfer && scan.err) err_q <= 1'b1;
        end
    end

    assign o_data_out   = data_q;
    assign o_valid_out  = valid_q;
    assign o_sop_out    = sop_q;
    assign o_eop_out    = eop_q;
    assign o_grant_port = grant_q;
    assign o_proto_err  = err_q;

endmodule

// File: tb/tb_fabric_port_out_arbiter.sv
// Directed bench for fabric_port_out_arbiter: grants, packet locking, backpressure,
// mid-packet lane boundaries, protocol errors and asynchronous reset.
module tb_fabric_port_out_arbiter;

    localparam int N = 2;
    localparam int W = 546;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   data_in;
    logic [4*N-1:0]   valid_in, sop_in, eop_in;
    logic [N-1:0]     ready_out;
    logic [W-1:0]     data_out;
    logic [3:0]       valid_out, sop_out, eop_out;
    logic             ready_in;
    logic [0:0]       grant_port;
    logic             proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    fabric_port_out_arbiter #(.N_PORTS(N), .WIDTH_DATA(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data_in    (data_in),
        .i_valid_in   (valid_in),
        .i_sop_in     (sop_in),
        .i_eop_in     (eop_in),
        .i_ready_out  (ready_out),
        .o_data_out   (data_out),
        .o_valid_out  (valid_out),
        .o_sop_out    (sop_out),
        .o_eop_out    (eop_out),
        .o_ready_in   (ready_in),
        .o_grant_port (grant_port),
        .o_proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] pat(input logic [7:0] b);
        logic [551:0] t;
        t = {69{b}};
        return t[W-1:0];
    endfunction

    task automatic put(input int p, input logic [3:0] v, input logic [3:0] s,
                       input logic [3:0] e, input logic [7:0] b);
        data_in[p*W +: W]  = pat(b);
        valid_in[p*4 +: 4] = v;
        sop_in[p*4 +: 4]   = s;
        eop_in[p*4 +: 4]   = e;
    endtask

    task automatic clr(input int p);
        put(p, 4'h0, 4'h0, 4'h0, 8'h00);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One line per beat leaving the output register.
    always @(negedge clk)
        if (!rst && (|valid_out) && ready_in)
            $display("out beat: port=%0d valid=%h sop=%h eop=%h data[7:0]=%h",
                     grant_port, valid_out, sop_out, eop_out, data_out[7:0]);

    initial begin
        ready_in = 1'b1;
        clr(0);
        clr(1);
        #12;
        check("rst_valid", valid_out, 4'h0);
        check("rst_sop", sop_out, 4'h0);
        check("rst_eop", eop_out, 4'h0);
        check("rst_data", data_out, '0);
        check("rst_grant", grant_port, 1'b0);
        check("rst_err", proto_err, 1'b0);
        rst = 1'b0;

        // single-beat packet on port 1 (rr_ptr 0 scans past idle port 0)
        put(1, 4'hF, 4'h8, 4'h1, 8'hA5);
        #1 check("t1_ready", ready_out, 2'b10);
        tick;
        check("t1_valid", valid_out, 4'hF);
        check("t1_sop", sop_out, 4'h8);
        check("t1_eop", eop_out, 4'h1);
        check("t1_data", data_out, pat(8'hA5));
        check("t1_grant", grant_port, 1'b1);
        check("t1_err", proto_err, 1'b0);
        clr(1);
        #1 check("t1_idle_ready", ready_out, 2'b00);
        tick;
        check("t1_drain", valid_out, 4'h0);

        // two simultaneous 3-beat packets: port 0 whole packet, then port 1
        for (int c = 0; c < 6; c++) begin
            int b1;
            b1 = (c < 3) ? 0 : c - 3;
            if (c < 3) put(0, 4'hF, (c == 0) ? 4'h8 : 4'h0, (c == 2) ? 4'h1 : 4'h0, 8'h20 + 8'(c));
            else clr(0);
            put(1, 4'hF, (b1 == 0) ? 4'h8 : 4'h0, (b1 == 2) ? 4'h1 : 4'h0, 8'h30 + 8'(b1));
            #1 check("t2_ready", ready_out, (c < 3) ? 2'b01 : 2'b10);
            tick;
            check("t2_grant", grant_port, (c < 3) ? 1'b0 : 1'b1);
            check("t2_data", data_out, (c < 3) ? pat(8'h20 + 8'(c)) : pat(8'h30 + 8'(b1)));
            check("t2_sop", sop_out, (c == 0 || c == 3) ? 4'h8 : 4'h0);
        end
        clr(1);
        tick;

        // lock held through port 0 bubbles while port 1 waits
        put(0, 4'hF, 4'h8, 4'h0, 8'h40);
        put(1, 4'h8, 4'h8, 4'h8, 8'h41);
        #1 check("t3_ready_first", ready_out, 2'b01);
        tick;
        check("t3_data0", data_out, pat(8'h40));
        clr(0);
        for (int k = 0; k < 2; k++) begin
            #1 check("t3_bubble_ready", ready_out, 2'b01);
            tick;
            check("t3_bubble_valid", valid_out, 4'h0);
        end
        put(0, 4'hF, 4'h0, 4'h1, 8'h42);
        #1 check("t3_resume_ready", ready_out, 2'b01);
        tick;
        check("t3_data_end", data_out, pat(8'h42));
        check("t3_eop", eop_out, 4'h1);
        clr(0);
        #1 check("t3_p1_ready", ready_out, 2'b10);
        tick;
        check("t3_p1_valid", valid_out, 4'h8);
        check("t3_p1_eop", eop_out, 4'h8);
        check("t3_p1_data", data_out, pat(8'h41));
        check("t3_err", proto_err, 1'b0);
        clr(1);

        // backpressure with a pending output beat
        put(0, 4'hF, 4'h8, 4'h1, 8'h50);
        #1 check("t4_ready", ready_out, 2'b01);
        tick;
        check("t4_data", data_out, pat(8'h50));
        ready_in = 1'b0;
        put(0, 4'hF, 4'h8, 4'h1, 8'h51);
        put(1, 4'hF, 4'h8, 4'h1, 8'h52);
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_stall_ready", ready_out, 2'b00);
            tick;
            check("t4_stall_valid", valid_out, 4'hF);
            check("t4_stall_data", data_out, pat(8'h50));
        end
        ready_in = 1'b1;
        #1 check("t4_release_ready", ready_out, 2'b10);
        tick;
        check("t4_next_data", data_out, pat(8'h52));
        check("t4_next_grant", grant_port, 1'b1);
        clr(1);
        #1 check("t4_p0_ready", ready_out, 2'b01);
        tick;
        check("t4_p0_data", data_out, pat(8'h51));
        clr(0);
        tick;
        check("t4_drain", valid_out, 4'h0);

        // eop lane 2 + sop lane 1 keeps port 1 locked
        put(1, 4'hF, 4'h8, 4'h0, 8'h60);
        #1 check("t5_ready_a", ready_out, 2'b10);
        tick;
        check("t5_data_a", data_out, pat(8'h60));
        put(1, 4'hF, 4'h2, 4'h4, 8'h61);
        put(0, 4'hF, 4'h8, 4'h1, 8'h63);
        #1 check("t5_ready_b", ready_out, 2'b10);
        tick;
        check("t5_sop_b", sop_out, 4'h2);
        check("t5_eop_b", eop_out, 4'h4);
        put(1, 4'hF, 4'h0, 4'h1, 8'h62);
        #1 check("t5_ready_c", ready_out, 2'b10);
        tick;
        check("t5_data_c", data_out, pat(8'h62));
        check("t5_err", proto_err, 1'b0);
        clr(1);
        #1 check("t5_release_ready", ready_out, 2'b01);
        tick;
        check("t5_p0_data", data_out, pat(8'h63));
        check("t5_p0_grant", grant_port, 1'b0);
        clr(0);

        // data beat with no open packet: flagged but still forwarded
        put(1, 4'hF, 4'h0, 4'h0, 8'h70);
        #1 check("t6_ready", ready_out, 2'b10);
        tick;
        check("t6_err", proto_err, 1'b1);
        check("t6_valid", valid_out, 4'hF);
        check("t6_data", data_out, pat(8'h70));
        clr(1);
        tick;

        // asynchronous reset mid-packet
        put(0, 4'hF, 4'h8, 4'h0, 8'h80);
        tick;
        check("t7_pre_data", data_out, pat(8'h80));
        rst = 1'b1;
        #1;
        check("t7_rst_valid", valid_out, 4'h0);
        check("t7_rst_err", proto_err, 1'b0);
        check("t7_rst_data", data_out, '0);
        #2 rst = 1'b0;
        clr(0);
        put(1, 4'h8, 4'h8, 4'h8, 8'h81);
        #1 check("t7_p1_ready", ready_out, 2'b10);
        tick;
        check("t7_p1_data", data_out, pat(8'h81));
        check("t7_p1_grant", grant_port, 1'b1);
        clr(1);
        put(0, 4'hF, 4'h8, 4'h1, 8'h82);
        #1 check("t7_p0_ready", ready_out, 2'b01);
        tick;
        check("t7_p0_data", data_out, pat(8'h82));
        check("t7_p0_sop", sop_out, 4'h8);
        check("t7_p0_err", proto_err, 1'b0);
        clr(0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fabric_port_out_arbiter.md
Name: fabric_port_out_arbiter

Overview:
- Shares one fabric-port output interface between N_PORTS depacketizer streams.
- Each input carries one 4-lane beat per cycle (data, valid[3:0], sop[3:0], eop[3:0]); lane 3 is the head lane and is first in packet order.
- Round-robin arbitration; a grant is held from a packet's sop beat until its eop beat, so packets are never interleaved.
- Output is registered (1-cycle latency) and drives the downstream consumer with valid/ready.

Parameters:
N_PORTS, 2, number of depacketizer inputs (2..8)
WIDTH_DATA, 546, data bits per beat (512+32+1+1)
PTR_W, $clog2(N_PORTS), width of grant/pointer index (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
i_data_in  input  N_PORTS*WIDTH_DATA  beat data; port k occupies bits [k*WIDTH_DATA +: WIDTH_DATA]
i_valid_in  input  4*N_PORTS  per-lane valid; port k occupies [4k +: 4]
i_sop_in  input  4*N_PORTS  per-lane start-of-packet
i_eop_in  input  4*N_PORTS  per-lane end-of-packet
i_ready_out  output  N_PORTS  per-port ready (combinational)
o_data_out  output  WIDTH_DATA  registered beat data
o_valid_out  output  4  registered lane valids
o_sop_out  output  4  registered lane sop
o_eop_out  output  4  registered lane eop
o_ready_in  input  1  downstream ready
o_grant_port  output  PTR_W  port index of the beat in the output register (debug)
o_proto_err  output  1  sticky protocol-error flag

Behaviour:
- Beat present on port k: |i_valid_in[4k+:4]. Lane bits with valid=0 are ignored.
- accept = !out_vld | o_ready_in, where out_vld = |o_valid_out.
- i_ready_out[k] = accept & grant_onehot[k]. Transfer on port k = beat present & i_ready_out[k].
- Transfer loads the output register on the same edge. Accept without a transfer loads o_valid_out=0.
- When accept=0, the output register holds its contents unchanged.
- Packet-open tracking per beat: scan lanes 3→0 over valid lanes only, starting from the port's current open state.
  - sop sets open; eop clears open.
  - A lane with both sop and eop is a single-lane packet and leaves open=0.
- FSM states:
  - IDLE: grant = first port with a beat present, searching rr_ptr, rr_ptr+1, … modulo N_PORTS. On transfer: if the beat leaves open=1, go to LOCKED(lock_port=k); otherwise stay in IDLE and set rr_ptr=k+1 mod N_PORTS.
  - LOCKED: grant only lock_port; all other ready=0. On a transfer whose beat leaves open=0, go to IDLE and set rr_ptr=lock_port+1 mod N_PORTS.
  - Lock is held through bubbles: port valid=0 or o_ready_in=0 do not release it.
- A beat may close one packet and open another (eop in lane 2, sop in lane 1). The resulting open=1 keeps or enters LOCKED.
- Protocol errors set o_proto_err=1 until reset; data still forwards unchanged:
  - valid sop lane while open=1;
  - valid eop lane while open=0 that is not paired with sop in the same lane;
  - valid non-sop lane while open=0.
- Reset (asynchronous, any time including mid-packet):
  - state=IDLE, rr_ptr=0, lock_port=0;
  - o_valid_out=0, o_sop_out=0, o_eop_out=0, o_data_out=0, o_grant_port=0, o_proto_err=0.
  - In-flight packets are dropped; no recovery.
- No combinational path from o_ready_in to i_valid_in is required or allowed upstream.
- Latency: input transfer at edge t → visible on outputs after edge t.

Decomposition:
- fabric_port_pkg holds: NUM_LANES=4; the lane-order convention (lane 3 = head); the arbiter state enum (ST_IDLE, ST_LOCKED); the default WIDTH_DATA constant.
- Sub-module fabric_port_rr_arb: N-way round-robin priority selector. Inputs: request vector and rr_ptr. Outputs: one-hot grant and index. Purely combinational.
- The FSM, open-tracking and output register stay in the top module.

Test Plan:
- Single port, 1-beat packet (valid=4'b1111, sop=4'b1000, eop=4'b0001, data=0xA5…) with o_ready_in=1 → outputs match one cycle later; state stays IDLE; o_proto_err=0.
- Ports 0 and 1 each send a 3-beat packet simultaneously → port 0's beats first (rr_ptr=0), then port 1's 3 beats; no interleave; rr_ptr returns to 0.
- Port 0 mid-packet drops valid for 2 cycles while port 1 is requesting → port 1 ready stays 0; lock held; port 0 resumes and completes.
- o_ready_in=0 for 3 cycles with an output beat pending → o_* stable; all i_ready_out=0; beat delivered exactly once after release.
- Beat with eop lane 2 and sop lane 1 on port 1, then eop-only beat → stays LOCKED across both; releases after the second beat.
- Reset asserted mid-packet, then port 1 requests → o_valid_out=0 immediately; port 1 granted first (rr_ptr=0 scan); sop on port 0 after reset does not raise o_proto_err.
